// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Requester indices, FSM state encoding, lock timeout and default widths.
package regfile_write_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;

  localparam int LOCK_TIMEOUT = 16;
  localparam int LOCK_CNT_W   = $clog2(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
// On contention the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // last resets to 1 so requester 0 wins the first contended grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (gnt_o != 2'b00) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU (req 0) and load (req 1) writeback sources.
// Optional per-requester saturating grant counters when REGARB_GRANT_CNT_EN is defined.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              ack0,
  output logic              ack1,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic [NREG-1:0]   busy_mask,
  output logic              drop,
  output logic [1:0]        state_o
`ifdef REGARB_GRANT_CNT_EN
  ,
  output logic [15:0]       gcnt0,
  output logic [15:0]       gcnt1
`endif
);

  // Handshake: a requester holds req with stable addr/data/lock until it sees
  // its ack; the ack cycle is the transfer, so the next edge consumes the request.

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]        req_m;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_lock;

  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] wa3_q, wa3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              drop_q, drop_d;

  // While locked only the owner may compete; nothing is granted during reset.
  always_comb begin
    req_m = {req1, req0} & {2{rst_n}};
    if (state_q == ST_LOCK) begin
      req_m = owner_q ? (req_m & 2'b10) : (req_m & 2'b01);
    end
  end

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_m),
    .gnt_o (gnt)
  );

  assign ack0     = gnt[REQ_ALU];
  assign ack1     = gnt[REQ_LD];
  assign any_gnt  = |gnt;
  assign sel      = gnt[REQ_LD];
  assign sel_addr = sel ? addr1 : addr0;
  assign sel_data = sel ? data1 : data0;
  assign sel_lock = sel ? lock1 : lock0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_WR: begin
        if (any_gnt) begin
          cnt_d = '0;
          if (sel_lock) begin
            state_d = ST_LOCK;
            owner_d = sel;
          end else begin
            state_d = ST_WR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (any_gnt) begin
          cnt_d   = '0;
          state_d = sel_lock ? ST_LOCK : ST_WR;
        end else if (cnt_q == LOCK_CNT_W'(LOCK_TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = ST_WR;
        end else begin
          cnt_d = cnt_q + LOCK_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Writes to r0 are acknowledged but turned into a drop pulse instead of a write.
  always_comb begin
    we3_d  = any_gnt && (sel_addr != '0);
    drop_d = any_gnt && (sel_addr == '0);
    wa3_d  = we3_d ? sel_addr : '0;
    wd3_d  = we3_d ? sel_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
      drop_q  <= drop_d;
    end
  end

  assign we3     = we3_q;
  assign wa3     = wa3_q;
  assign wd3     = wd3_q;
  assign drop    = drop_q;
  assign state_o = state_q;

  always_comb begin
    busy_mask = '0;
    if (we3_q) busy_mask[wa3_q] = 1'b1;
  end

`ifdef REGARB_GRANT_CNT_EN
  logic [15:0] gcnt0_q, gcnt1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (gnt[REQ_ALU] && (gcnt0_q != 16'hFFFF)) gcnt0_q <= gcnt0_q + 16'd1;
      if (gnt[REQ_LD] && (gcnt1_q != 16'hFFFF)) gcnt1_q <= gcnt1_q + 16'd1;
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
`else
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-cycle vector table plus lock-timeout
// and (with REGARB_GRANT_CNT_EN) grant-counter saturation sequences.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, lock0, lock1;
  logic [2:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic        ack0, ack1, we3, drop;
  logic [2:0]  wa3;
  logic [15:0] wd3;
  logic [7:0]  busy_mask;
  logic [1:0]  state_o;
`ifdef REGARB_GRANT_CNT_EN
  logic [15:0] gcnt0, gcnt1;
`endif

  int n_checks = 0;
  int n_err    = 0;

  regfile_write_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .data0     (data0),
    .data1     (data1),
    .lock0     (lock0),
    .lock1     (lock1),
    .ack0      (ack0),
    .ack1      (ack1),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .busy_mask (busy_mask),
    .drop      (drop),
    .state_o   (state_o)
`ifdef REGARB_GRANT_CNT_EN
    ,
    .gcnt0     (gcnt0),
    .gcnt1     (gcnt1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        r0;
    logic [2:0]  a0;
    logic [15:0] d0;
    logic        l0;
    logic        r1;
    logic [2:0]  a1;
    logic [15:0] d1;
    logic        l1;
    logic        e_ack0;
    logic        e_ack1;
    logic        e_we;
    logic [2:0]  e_wa;
    logic [15:0] e_wd;
    logic [7:0]  e_busy;
    logic        e_drop;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic r0, input logic [2:0] a0, input logic [15:0] d0,
                       input logic l0, input logic r1, input logic [2:0] a1, input logic [15:0] d1,
                       input logic l1);
    rst_n = rst; req0 = r0; addr0 = a0; data0 = d0; lock0 = l0;
    req1 = r1; addr1 = a1; data1 = d1; lock1 = l1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst r0 a0 d0 l0 r1 a1 d1 l1 | ack0 ack1 we wa wd busy drop state
    vq.push_back('{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, ST_IDLE});
    vq.push_back('{1'b1, 1'b1, 3'd3, 16'h00A5, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, ST_IDLE});
    vq.push_back('{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h00A5, 8'h08, 1'b0, ST_WR});
    vq.push_back('{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, ST_IDLE});
    vq.push_back('{1'b1, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, ST_IDLE});
    vq.push_back('{1'b1, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h1111, 8'h02, 1'b0, ST_WR});
    vq.push_back('{1'b1, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h2222, 8'h04, 1'b0, ST_WR});
    vq.push_back('{1'b1, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 16'h1111, 8'h02, 1'b0, ST_WR});
    vq.push_back('{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h2222, 8'h04, 1'b0, ST_WR});
    vq.push_back('{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, ST_IDLE});
    vq.push_back('{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, ST_WR});
    vq.push_back('{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd5, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, ST_IDLE});
    vq.push_back('{1'b1, 1'b1, 3'd6, 16'h6666, 1'b0, 1'b1, 3'd7, 16'h7777, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 16'h5555, 8'h20, 1'b0, ST_LOCK});
    vq.push_back('{1'b1, 1'b1, 3'd6, 16'h6666, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 16'h7777, 8'h80, 1'b0, ST_WR});
    vq.push_back('{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'h6666, 8'h40, 1'b0, ST_WR});
    vq.push_back('{1'b1, 1'b1, 3'd3, 16'h0033, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, ST_IDLE});
    vq.push_back('{1'b0, 1'b1, 3'd3, 16'h0033, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0033, 8'h08, 1'b0, ST_WR});
    vq.push_back('{1'b1, 1'b1, 3'd3, 16'h0033, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00, 1'b0, ST_IDLE});
    vq.push_back('{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0033, 8'h08, 1'b0, ST_WR});

    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    next_cycle();
    next_cycle();

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].r0, vq[i].a0, vq[i].d0, vq[i].l0, vq[i].r1, vq[i].a1, vq[i].d1, vq[i].l1);
      @(negedge clk);
      chk($sformatf("v%0d ack0", i), 32'(ack0), 32'(vq[i].e_ack0));
      chk($sformatf("v%0d ack1", i), 32'(ack1), 32'(vq[i].e_ack1));
      chk($sformatf("v%0d we3", i), 32'(we3), 32'(vq[i].e_we));
      if (vq[i].e_we) begin
        chk($sformatf("v%0d wa3", i), 32'(wa3), 32'(vq[i].e_wa));
        chk($sformatf("v%0d wd3", i), 32'(wd3), 32'(vq[i].e_wd));
      end
      chk($sformatf("v%0d busy_mask", i), 32'(busy_mask), 32'(vq[i].e_busy));
      chk($sformatf("v%0d drop", i), 32'(drop), 32'(vq[i].e_drop));
      chk($sformatf("v%0d state", i), 32'(state_o), 32'(vq[i].e_st));
      next_cycle();
    end

    // Lock timeout: requester 0 locks, then goes quiet while requester 1 waits.
    drive(1'b1, 1'b1, 3'd2, 16'h0202, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    chk("lock_grant ack0", 32'(ack0), 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 3'd4, 16'h0404, 1'b0);
    for (int k = 0; k < LOCK_TIMEOUT; k++) begin
      @(negedge clk);
      chk($sformatf("lock_idle%0d ack1", k), 32'(ack1), 32'd0);
      chk($sformatf("lock_idle%0d state", k), 32'(state_o), 32'(ST_LOCK));
      if (k == 0) chk("lock_write wa3", 32'(wa3), 32'd2);
      next_cycle();
    end
    @(negedge clk);
    chk("lock_timeout state", 32'(state_o), 32'(ST_WR));
    chk("lock_timeout ack1", 32'(ack1), 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    chk("after_timeout wa3", 32'(wa3), 32'd4);
    chk("after_timeout wd3", 32'(wd3), 32'h0404);
    chk("after_timeout busy_mask", 32'(busy_mask), 32'h10);
    next_cycle();

`ifdef REGARB_GRANT_CNT_EN
    drive(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    repeat (100) next_cycle();
    @(negedge clk);
    chk("gcnt0 after 100", 32'(gcnt0), 32'd100);
    next_cycle();
    repeat (69899) next_cycle();
    @(negedge clk);
    chk("gcnt0 saturated", 32'(gcnt0), 32'hFFFF);
    chk("gcnt1 unchanged", 32'(gcnt1), 32'd0);
    drive(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
